// File: rtl/gate_vector_checker.sv
// gate_vector_checker: exhaustive truth-table tester for a 2-input gate.
// Drives the four {tb,ta} vectors in order 00,01,10,11, holds each for
// SETTLE_CYCLES+1 cycles, samples y in the last cycle against the latched
// truth table, and reports a mismatch mask, a count and a pass flag.
module gate_vector_checker #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] truth,
  output logic       ta,
  output logic       tb,
  input  logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] err_mask
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [1:0] v_q, v_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] truth_q, truth_d;
  logic       ta_q, ta_d;
  logic       tb_q, tb_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [2:0] err_count_q, err_count_d;
  logic [3:0] err_mask_q, err_mask_d;

  // Next-state and registered-output computation for the test sequencer.
  // The final SAMPLE derives pass from err_count_d so a mismatch on the
  // last vector is reflected in the same edge that enters DONE.
  always_comb begin
    state_d     = state_q;
    v_d         = v_q;
    cnt_d       = cnt_q;
    truth_d     = truth_q;
    ta_d        = ta_q;
    tb_d        = tb_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    err_count_d = err_count_q;
    err_mask_d  = err_mask_q;

    case (state_q)
      IDLE: begin
        ta_d   = 1'b0;
        tb_d   = 1'b0;
        busy_d = 1'b0;
        if (start) begin
          truth_d     = truth;
          err_count_d = '0;
          err_mask_d  = '0;
          pass_d      = 1'b0;
          v_d         = '0;
          cnt_d       = '0;
          busy_d      = 1'b1;
          state_d     = SETTLE;
        end
      end

      SETTLE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == SETTLE_LAST) begin
          state_d = SAMPLE;
        end
      end

      SAMPLE: begin
        if (y != truth_q[v_q]) begin
          err_mask_d = err_mask_q | (4'b0001 << v_q);
          if (err_count_q < 3'd4) begin
            err_count_d = err_count_q + 3'd1;
          end
        end
        if (v_q != 2'd3) begin
          v_d     = v_q + 2'd1;
          ta_d    = v_d[0];
          tb_d    = v_d[1];
          cnt_d   = '0;
          state_d = SETTLE;
        end else begin
          ta_d    = 1'b0;
          tb_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_count_d == 3'd0);
          state_d = DONE;
        end
      end

      DONE: begin
        ta_d    = 1'b0;
        tb_d    = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      v_q         <= '0;
      cnt_q       <= '0;
      truth_q     <= '0;
      ta_q        <= 1'b0;
      tb_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_count_q <= '0;
      err_mask_q  <= '0;
    end else begin
      state_q     <= state_d;
      v_q         <= v_d;
      cnt_q       <= cnt_d;
      truth_q     <= truth_d;
      ta_q        <= ta_d;
      tb_q        <= tb_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_count_q <= err_count_d;
      err_mask_q  <= err_mask_d;
    end
  end

  assign ta        = ta_q;
  assign tb        = tb_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_count_q;
  assign err_mask  = err_mask_q;

endmodule

// File: tb/tb_gate_vector_checker.sv
// Directed bench for gate_vector_checker: two instances (SETTLE_CYCLES=2
// and SETTLE_CYCLES=1) each driving a NAND model, with an option to tie
// y high on the first instance.
module tb_gate_vector_checker;

  logic       clk;
  logic       rst;
  logic       ytie;

  logic       st2, ta2, tb2, y2, busy2, done2, pass2;
  logic [3:0] truth2, em2;
  logic [2:0] ec2;

  logic       st1, ta1, tb1, y1, busy1, done1, pass1;
  logic [3:0] truth1, em1;
  logic [2:0] ec1;

  int n_vec;
  int n_miss;

  assign y2 = ytie ? 1'b1 : ~(ta2 & tb2);
  assign y1 = ~(ta1 & tb1);

  gate_vector_checker #(.SETTLE_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .start(st2), .truth(truth2),
    .ta(ta2), .tb(tb2), .y(y2),
    .busy(busy2), .done(done2), .pass(pass2),
    .err_count(ec2), .err_mask(em2)
  );

  gate_vector_checker #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(st1), .truth(truth1),
    .ta(ta1), .tb(tb1), .y(y1),
    .busy(busy1), .done(done1), .pass(pass1),
    .err_count(ec1), .err_mask(em1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One run on the selected instance; samples #1 after every edge.
  task automatic run(input bit sel, input logic [3:0] tv, input int nedges, input bit repulse,
                     output int done_edge, output int done_cnt, output logic [31:0] seq,
                     output logic busy_last, output logic busy_done, output logic [1:0] tt_done,
                     output logic pass_acc);
    logic [1:0] pair;
    @(negedge clk);
    if (sel) begin truth1 = tv; st1 = 1'b1; end
    else     begin truth2 = tv; st2 = 1'b1; end
    @(posedge clk); #1;
    st1 = 1'b0;
    st2 = 1'b0;
    pass_acc  = sel ? pass1 : pass2;
    pair      = sel ? {ta1, tb1} : {ta2, tb2};
    seq       = {30'd0, pair};
    done_edge = -1;
    done_cnt  = 0;
    busy_last = 1'b0;
    busy_done = 1'b1;
    tt_done   = 2'b11;
    for (int k = 1; k <= nedges + 4; k++) begin
      @(posedge clk); #1;
      if (repulse && k == 4) begin st2 = 1'b1; truth2 = 4'b1111; end
      if (repulse && k == 6) st2 = 1'b0;
      pair = sel ? {ta1, tb1} : {ta2, tb2};
      if (k < nedges) seq = (seq << 2) | {30'd0, pair};
      if (k == nedges - 1) busy_last = sel ? busy1 : busy2;
      if (k == nedges) begin
        busy_done = sel ? busy1 : busy2;
        tt_done   = pair;
      end
      if (sel ? done1 : done2) begin
        done_cnt++;
        if (done_edge < 0) done_edge = k;
      end
    end
  endtask

  int          de, dc, d1, d2;
  logic [31:0] sq;
  logic        bl, bd, pa, b13, b14;
  logic [1:0]  td;

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst    = 1'b1;
    ytie   = 1'b0;
    st1    = 1'b0;
    st2    = 1'b0;
    truth1 = 4'b0000;
    truth2 = 4'b0000;
    repeat (3) @(negedge clk);
    check_eq("reset_dut2", {21'd0, ta2, tb2, busy2, done2, pass2, ec2, em2}, 32'd0);
    check_eq("reset_dut1", {21'd0, ta1, tb1, busy1, done1, pass1, ec1, em1}, 32'd0);
    rst = 1'b0;

    // NAND, correct truth table, SETTLE_CYCLES=2
    run(1'b0, 4'b0111, 12, 1'b0, de, dc, sq, bl, bd, td, pa);
    check_eq("a_done_edge", de, 12);
    check_eq("a_done_cnt", dc, 1);
    check_eq("a_seq", sq, 32'h0002A57F);
    check_eq("a_busy_last", {31'd0, bl}, 1);
    check_eq("a_busy_done", {31'd0, bd}, 0);
    check_eq("a_tatb_done", {30'd0, td}, 0);
    check_eq("a_pass", {31'd0, pass2}, 1);
    check_eq("a_err_count", {29'd0, ec2}, 0);
    check_eq("a_err_mask", {28'd0, em2}, 0);

    // start re-pulsed and truth changed mid-run: both ignored
    run(1'b0, 4'b0111, 12, 1'b1, de, dc, sq, bl, bd, td, pa);
    check_eq("d_pass_cleared", {31'd0, pa}, 0);
    check_eq("d_done_edge", de, 12);
    check_eq("d_done_cnt", dc, 1);
    check_eq("d_seq", sq, 32'h0002A57F);
    check_eq("d_pass", {31'd0, pass2}, 1);
    check_eq("d_err_mask", {28'd0, em2}, 0);

    // y stuck high: only vector 3 (expected 0) mismatches
    ytie = 1'b1;
    run(1'b0, 4'b0111, 12, 1'b0, de, dc, sq, bl, bd, td, pa);
    ytie = 1'b0;
    check_eq("b_err_mask", {28'd0, em2}, 32'h8);
    check_eq("b_err_count", {29'd0, ec2}, 1);
    check_eq("b_pass", {31'd0, pass2}, 0);

    // NAND against AND truth: all four mismatch
    run(1'b0, 4'b1000, 12, 1'b0, de, dc, sq, bl, bd, td, pa);
    check_eq("c_err_mask", {28'd0, em2}, 32'hF);
    check_eq("c_err_count", {29'd0, ec2}, 4);
    check_eq("c_pass", {31'd0, pass2}, 0);
    repeat (5) @(posedge clk);
    #1;
    check_eq("c_hold", {24'd0, pass2, ec2, em2}, {24'd0, 1'b0, 3'd4, 4'hF});

    // SETTLE_CYCLES=1 instance
    run(1'b1, 4'b0111, 8, 1'b0, de, dc, sq, bl, bd, td, pa);
    check_eq("e_done_edge", de, 8);
    check_eq("e_done_cnt", dc, 1);
    check_eq("e_seq", sq, 32'h00000A5F);
    check_eq("e_pass", {31'd0, pass1}, 1);
    check_eq("e_err_count", {29'd0, ec1}, 0);

    // asynchronous reset during vector 2, then a fresh run
    @(negedge clk);
    truth2 = 4'b0111;
    st2    = 1'b1;
    @(posedge clk); #1;
    st2 = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check_eq("r_vec2", {30'd0, ta2, tb2}, 32'b01);
    #2;
    rst = 1'b1;
    #1;
    check_eq("r_async_clear", {21'd0, ta2, tb2, busy2, done2, pass2, ec2, em2}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dc = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (done2) dc++;
    end
    check_eq("r_no_done", dc, 0);
    run(1'b0, 4'b0111, 12, 1'b0, de, dc, sq, bl, bd, td, pa);
    check_eq("r_rerun_done_edge", de, 12);
    check_eq("r_rerun_pass", {31'd0, pass2}, 1);

    // start held high: second run accepted on the IDLE cycle after DONE
    @(negedge clk);
    truth2 = 4'b0111;
    st2    = 1'b1;
    @(posedge clk); #1;
    d1 = -1; d2 = -1; b13 = 1'b1; b14 = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (k == 13) b13 = busy2;
      if (k == 14) begin b14 = busy2; st2 = 1'b0; end
      if (done2) begin
        if (d1 < 0) d1 = k;
        else if (d2 < 0) d2 = k;
      end
    end
    check_eq("h_done1", d1, 12);
    check_eq("h_busy_idle", {31'd0, b13}, 0);
    check_eq("h_busy_rerun", {31'd0, b14}, 1);
    check_eq("h_done2", d2, 26);
    check_eq("h_pass", {31'd0, pass2}, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
